// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares the core's byte-wide RAM/IO port between instruction
// fetch (IF) and the load/store buffer (LSB).
//
// Each granted request (IF: 4-byte read; LSB: 1/2/4-byte load or store) is
// turned into byte-serial RAM cycles. Read bytes are assembled little-endian
// and zero-extended. Store words are split little-endian. The LSB has fixed
// priority over IF. A flush (clear_in) aborts only IF transactions.
//
// Ports:
//   clk_in, rst_n_in     clock, synchronous active-low reset
//   rdy_in               global ready; low pauses byte issue and grants
//   clear_in             pipeline flush (IF transactions only)
//   if_req/if_addr       IF read request (level) and address
//   if_done/if_data      one-cycle completion pulse and fetched word
//   ls_req/ls_wr/ls_len  LSB request, store flag, length (bytes - 1)
//   ls_addr/ls_wdata     LSB address and store data
//   ls_done/ls_rdata     one-cycle completion pulse and load data
//   mem_din              RAM read byte, valid the cycle after its address
//   mem_dout/mem_a/mem_wr registered RAM write byte, address, write strobe
//   io_buffer_full       UART TX buffer full
//
// Build option: define MEM_ARB_IO_STALL_EN to hold store bytes addressed at
// or above IO_BASE while io_buffer_full is high.

module mem_arbiter #(
    parameter int          ADDR_W  = 32,
    parameter logic [31:0] IO_BASE = 32'h30000
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic              clear_in,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              ls_req,
    input  logic              ls_wr,
    input  logic [1:0]        ls_len,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_done,
    output logic [31:0]       ls_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RD    = 2'd1;
    localparam logic [1:0] ST_WR    = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              own_if_q, own_if_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        len_q, len_d;
    logic              wr_q, wr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        issue_idx_q, issue_idx_d;
    logic [1:0]        cap_idx_q, cap_idx_d;
    logic              rd_vis_q, rd_vis_d;   // mem_a currently shows a read byte
    logic              cap_en_q, cap_en_d;   // mem_din this cycle belongs to us
    logic [31:0]       rdata_q, rdata_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic              mem_wr_q, mem_wr_d;
    logic              if_done_q, if_done_d;
    logic              ls_done_q, ls_done_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       ls_rdata_q, ls_rdata_d;

    // Arbitration: nothing is granted while a done pulse is out, so a
    // requester that has not yet dropped req cannot be re-granted.
    logic grant_ok, grant_ls, grant_if, flush;
    assign grant_ok = (state_q == ST_IDLE) && rdy_in && !if_done_q && !ls_done_q;
    assign grant_ls = grant_ok && ls_req;
    assign grant_if = grant_ok && !ls_req && if_req && !clear_in;
    assign flush    = own_if_q && clear_in && ((state_q == ST_RD) || (state_q == ST_DRAIN));

    // Issue source: byte 0 goes out straight from the grant so that it
    // appears on the bus the cycle after arbitration.
    logic              iss_active;
    logic [ADDR_W-1:0] iss_base;
    logic [1:0]        iss_len;
    logic              iss_wr;
    logic [31:0]       iss_wdata;
    logic [2:0]        iss_idx;

    always_comb begin
        iss_active = 1'b0;
        iss_base   = addr_q;
        iss_len    = len_q;
        iss_wr     = wr_q;
        iss_wdata  = wdata_q;
        iss_idx    = issue_idx_q;
        if (grant_ls) begin
            iss_active = 1'b1;
            iss_base   = ls_addr;
            iss_len    = ls_len;
            iss_wr     = ls_wr;
            iss_wdata  = ls_wdata;
            iss_idx    = 3'd0;
        end else if (grant_if) begin
            iss_active = 1'b1;
            iss_base   = if_addr;
            iss_len    = 2'd3;
            iss_wr     = 1'b0;
            iss_wdata  = 32'd0;
            iss_idx    = 3'd0;
        end else if ((state_q == ST_RD) || (state_q == ST_WR)) begin
            iss_active = (issue_idx_q <= {1'b0, len_q}) && !flush;
        end
    end

    logic [ADDR_W-1:0] byte_addr;
    logic              stall;
    logic              issue;
    assign byte_addr = iss_base + ADDR_W'(iss_idx);

`ifdef MEM_ARB_IO_STALL_EN
    assign stall = iss_wr && (byte_addr >= ADDR_W'(IO_BASE)) && io_buffer_full;
`else
    logic unused_io;
    assign unused_io = io_buffer_full ^ (^IO_BASE);
    assign stall     = 1'b0;
`endif

    assign issue = iss_active && rdy_in && !stall;

    // Capture path is not gated by rdy_in: a byte addressed in the last
    // ready cycle is still collected.
    logic [31:0] rdata_cap;
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign rdata_cap[8*gi +: 8] = (cap_en_q && (cap_idx_q == 2'(gi))) ?
                                      mem_din : rdata_q[8*gi +: 8];
    end

    always_comb begin
        state_d     = state_q;
        own_if_d    = own_if_q;
        addr_d      = addr_q;
        len_d       = len_q;
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        issue_idx_d = issue_idx_q;
        cap_idx_d   = cap_idx_q;
        rdata_d     = rdata_q;
        rd_vis_d    = 1'b0;
        cap_en_d    = rd_vis_q;
        mem_a_d     = mem_a_q;
        mem_dout_d  = mem_dout_q;
        mem_wr_d    = 1'b0;
        if_done_d   = 1'b0;
        ls_done_d   = 1'b0;
        if_data_d   = if_data_q;
        ls_rdata_d  = ls_rdata_q;

        if (cap_en_q) begin
            rdata_d   = rdata_cap;
            cap_idx_d = cap_idx_q + 2'd1;
        end

        if (issue) begin
            mem_a_d     = byte_addr;
            mem_wr_d    = iss_wr;
            mem_dout_d  = 8'(iss_wdata >> {iss_idx[1:0], 3'b000});
            issue_idx_d = iss_idx + 3'd1;
            rd_vis_d    = !iss_wr;
        end

        case (state_q)
            ST_IDLE: begin
                if (grant_ls || grant_if) begin
                    own_if_d  = grant_if;
                    addr_d    = iss_base;
                    len_d     = iss_len;
                    wr_d      = iss_wr;
                    wdata_d   = iss_wdata;
                    cap_idx_d = 2'd0;
                    rdata_d   = 32'd0;
                    if (!issue) begin
                        issue_idx_d = 3'd0;
                    end
                    if (iss_wr) begin
                        state_d = ST_WR;
                    end else if (issue_idx_d > {1'b0, iss_len}) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (issue_idx_d > {1'b0, len_q}) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_WR: begin
                // Last store byte was on the bus in the previous cycle.
                if (issue_idx_q > {1'b0, len_q}) begin
                    ls_done_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin // ST_DRAIN
                if (cap_en_q && (cap_idx_q == len_q)) begin
                    if (own_if_q) begin
                        if_done_d = 1'b1;
                        if_data_d = rdata_cap;
                    end else begin
                        ls_done_d  = 1'b1;
                        ls_rdata_d = rdata_cap;
                    end
                    state_d = ST_IDLE;
                end
            end
        endcase

        // A flushed fetch is abandoned outright, including any byte whose
        // data would still arrive next cycle.
        if (flush) begin
            state_d   = ST_IDLE;
            rd_vis_d  = 1'b0;
            cap_en_d  = 1'b0;
            if_done_d = 1'b0;
            if_data_d = if_data_q;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q     <= ST_IDLE;
            own_if_q    <= 1'b0;
            addr_q      <= '0;
            len_q       <= 2'd0;
            wr_q        <= 1'b0;
            wdata_q     <= 32'd0;
            issue_idx_q <= 3'd0;
            cap_idx_q   <= 2'd0;
            rd_vis_q    <= 1'b0;
            cap_en_q    <= 1'b0;
            rdata_q     <= 32'd0;
            mem_a_q     <= '0;
            mem_dout_q  <= 8'd0;
            mem_wr_q    <= 1'b0;
            if_done_q   <= 1'b0;
            ls_done_q   <= 1'b0;
            if_data_q   <= 32'd0;
            ls_rdata_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            own_if_q    <= own_if_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            wr_q        <= wr_d;
            wdata_q     <= wdata_d;
            issue_idx_q <= issue_idx_d;
            cap_idx_q   <= cap_idx_d;
            rd_vis_q    <= rd_vis_d;
            cap_en_q    <= cap_en_d;
            rdata_q     <= rdata_d;
            mem_a_q     <= mem_a_d;
            mem_dout_q  <= mem_dout_d;
            mem_wr_q    <= mem_wr_d;
            if_done_q   <= if_done_d;
            ls_done_q   <= ls_done_d;
            if_data_q   <= if_data_d;
            ls_rdata_q  <= ls_rdata_d;
        end
    end

    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    assign mem_wr   = mem_wr_q;
    assign if_done  = if_done_q;
    assign if_data  = if_data_q;
    assign ls_done  = ls_done_q;
    assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. A byte RAM model answers the DUT's
// memory port; expected data comes from a separate reference byte array
// updated from little-endian store rules.

module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in, clear_in;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_req, ls_wr;
    logic [1:0]  ls_len;
    logic [31:0] ls_addr, ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    always #5 clk_in = ~clk_in;

    mem_arbiter #(.ADDR_W(32), .IO_BASE(32'h30000)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ls_req(ls_req), .ls_wr(ls_wr), .ls_len(ls_len), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    // RAM model (4 KiB, address wraps) with a preload port for the bench.
    logic [7:0]  ram     [0:4095];
    logic [7:0]  ref_mem [0:4095];
    logic        pl_en = 1'b0;
    logic [11:0] pl_addr = 12'd0;
    logic [7:0]  pl_data = 8'd0;

    always @(posedge clk_in) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
        mem_din <= ram[mem_a[11:0]];
    end

    task automatic tick();
        @(negedge clk_in);
    endtask

    task automatic poke(input int a, input logic [7:0] d);
        pl_en   = 1'b1;
        pl_addr = 12'(a);
        pl_data = d;
        ref_mem[a & 4095] = d;
        tick();
        pl_en = 1'b0;
    endtask

    function automatic logic [31:0] exp_word(input int a, input int len);
        logic [31:0] w;
        w = 32'd0;
        for (int i = 0; i <= len; i++) w[8*i +: 8] = ref_mem[(a + i) & 4095];
        return w;
    endfunction

    function automatic logic [31:0] ram_word(input int a, input int len);
        logic [31:0] w;
        w = 32'd0;
        for (int i = 0; i <= len; i++) w[8*i +: 8] = ram[(a + i) & 4095];
        return w;
    endfunction

    task automatic idle_inputs();
        if_req = 0; if_addr = 0; ls_req = 0; ls_wr = 0; ls_len = 0;
        ls_addr = 0; ls_wdata = 0; clear_in = 0; rdy_in = 1; io_buffer_full = 0;
    endtask

    task automatic test_reset();
        int seen;
        rst_n_in = 1'b0;
        idle_inputs();
        tick(); tick();
        for (int a = 0; a < 4096; a++) poke(a, 8'($urandom));
        total++; if (mem_a !== 32'd0) begin bad++; $display("FAIL reset_mem_a got=%h want=0", mem_a); end
        total++; if (mem_dout !== 8'd0) begin bad++; $display("FAIL reset_mem_dout got=%h want=0", mem_dout); end
        total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL reset_mem_wr got=%b want=0", mem_wr); end
        total++; if (if_done !== 1'b0) begin bad++; $display("FAIL reset_if_done got=%b want=0", if_done); end
        total++; if (ls_done !== 1'b0) begin bad++; $display("FAIL reset_ls_done got=%b want=0", ls_done); end
        total++; if (if_data !== 32'd0) begin bad++; $display("FAIL reset_if_data got=%h want=0", if_data); end
        total++; if (ls_rdata !== 32'd0) begin bad++; $display("FAIL reset_ls_rdata got=%h want=0", ls_rdata); end
        rst_n_in = 1'b1;
        tick();
        // Reset in the middle of a fetch: no done pulse may follow.
        if_req = 1; if_addr = 32'h80;
        tick(); tick(); tick();
        rst_n_in = 1'b0; if_req = 0;
        tick();
        total++; if (mem_a !== 32'd0) begin bad++; $display("FAIL reset_mid_mem_a got=%h want=0", mem_a); end
        rst_n_in = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (if_done === 1'b1 || ls_done === 1'b1) seen = 1;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL reset_mid_done got=%0d want=0", seen); end
        $display("reset test complete");
    endtask

    task automatic test_if_fetch();
        int t, at, npulse;
        logic [31:0] got;
        poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h00); poke(32'h103, 8'h00);
        tick();
        t = cyc; at = -1; npulse = 0; got = 0;
        if_req = 1; if_addr = 32'h100;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k <= 4) begin
                total++;
                if (mem_a !== 32'h100 + 32'(k - 1) || mem_wr !== 1'b0) begin
                    bad++; $display("FAIL if_fetch_addr k=%0d got=%h want=%h", k, mem_a, 32'h100 + 32'(k - 1));
                end
            end
            if (if_done === 1'b1) begin
                npulse++;
                if (at < 0) begin at = cyc - t; got = if_data; if_req = 0; end
            end
        end
        total++; if (at != 6) begin bad++; $display("FAIL if_fetch_latency got=%0d want=6", at); end
        total++; if (got !== 32'h00000513) begin bad++; $display("FAIL if_fetch_data got=%h want=00000513", got); end
        total++; if (npulse != 1) begin bad++; $display("FAIL if_fetch_pulses got=%0d want=1", npulse); end
        $display("if fetch: latency=%0d data=%h", at, got);
    endtask

    task automatic test_priority();
        int t, ls_at, if_at, first_if;
        logic [31:0] ia, ls_got, if_got;
        poke(32'h20, 8'hAB);
        ia = 32'h300 + 4 * 32'($urandom_range(0, 63));
        tick();
        t = cyc; ls_at = -1; if_at = -1; first_if = -1; ls_got = 0; if_got = 0;
        if_req = 1; if_addr = ia;
        ls_req = 1; ls_wr = 0; ls_len = 0; ls_addr = 32'h20;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (ls_at >= 0 && first_if < 0 && mem_a === ia) first_if = cyc - t;
            if (ls_done === 1'b1 && ls_at < 0) begin ls_at = cyc - t; ls_got = ls_rdata; ls_req = 0; end
            if (if_done === 1'b1 && if_at < 0) begin if_at = cyc - t; if_got = if_data; if_req = 0; end
        end
        total++; if (ls_at != 3) begin bad++; $display("FAIL prio_ls_latency got=%0d want=3", ls_at); end
        total++; if (ls_got !== 32'h000000AB) begin bad++; $display("FAIL prio_ls_data got=%h want=000000ab", ls_got); end
        total++; if (first_if != 5) begin bad++; $display("FAIL prio_if_first_byte got=%0d want=5", first_if); end
        total++; if (if_at != 10) begin bad++; $display("FAIL prio_if_latency got=%0d want=10", if_at); end
        total++; if (if_got !== exp_word(int'(ia), 3)) begin bad++; $display("FAIL prio_if_data got=%h want=%h", if_got, exp_word(int'(ia), 3)); end
        $display("priority: ls_done@%0d if_first@%0d if_done@%0d", ls_at, first_if, if_at);
    endtask

    task automatic test_store();
        int t, at;
        logic [31:0] wa;
        logic [7:0] wd;
        tick();
        t = cyc; at = -1;
        ls_req = 1; ls_wr = 1; ls_len = 1; ls_addr = 32'h40; ls_wdata = 32'h1234;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k <= 2) begin
                wa = 32'h40 + 32'(k - 1);
                wd = (k == 1) ? 8'h34 : 8'h12;
                total++;
                if (mem_wr !== 1'b1 || mem_a !== wa || mem_dout !== wd) begin
                    bad++; $display("FAIL store_byte k=%0d got=%b/%h/%h want=1/%h/%h", k, mem_wr, mem_a, mem_dout, wa, wd);
                end
            end else begin
                total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL store_idle_wr k=%0d got=%b want=0", k, mem_wr); end
            end
            if (ls_done === 1'b1 && at < 0) begin at = cyc - t; ls_req = 0; ls_wr = 0; end
        end
        ref_mem[32'h40] = 8'h34; ref_mem[32'h41] = 8'h12;
        total++; if (at != 3) begin bad++; $display("FAIL store_latency got=%0d want=3", at); end
        total++; if (ram_word(32'h40, 1) !== exp_word(32'h40, 1)) begin bad++; $display("FAIL store_ram got=%h want=%h", ram_word(32'h40, 1), exp_word(32'h40, 1)); end
        $display("store: ls_done@%0d", at);
    endtask

    task automatic test_rdy_stall();
        int t, at, wr_seen;
        logic [31:0] ia, got;
        ia = 32'h180;
        tick();
        t = cyc; at = -1; wr_seen = 0; got = 0;
        if_req = 1; if_addr = ia;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 2) begin total++; if (mem_a !== ia + 1) begin bad++; $display("FAIL rdy_byte1 got=%h want=%h", mem_a, ia + 1); end end
            if (k == 5) begin total++; if (mem_a !== ia + 2) begin bad++; $display("FAIL rdy_byte2 got=%h want=%h", mem_a, ia + 2); end end
            if (k == 6) begin total++; if (mem_a !== ia + 3) begin bad++; $display("FAIL rdy_byte3 got=%h want=%h", mem_a, ia + 3); end end
            if (mem_wr === 1'b1) wr_seen = 1;
            if (if_done === 1'b1 && at < 0) begin at = cyc - t; got = if_data; if_req = 0; end
            if (k == 2) rdy_in = 0;
            if (k == 4) rdy_in = 1;
        end
        total++; if (at != 8) begin bad++; $display("FAIL rdy_latency got=%0d want=8", at); end
        total++; if (got !== exp_word(int'(ia), 3)) begin bad++; $display("FAIL rdy_data got=%h want=%h", got, exp_word(int'(ia), 3)); end
        total++; if (wr_seen != 0) begin bad++; $display("FAIL rdy_spurious_wr got=%0d want=0", wr_seen); end
        $display("rdy stall: if_done@%0d data=%h", at, got);
    endtask

    task automatic test_clear();
        int t, at, if_seen, llen, nwr;
        logic [31:0] ia, la, sa, wd, got;
        ia = 32'h1C0;
        la = 32'h500 + 32'($urandom_range(0, 255));
        llen = $urandom_range(0, 2);
        if (llen == 2) llen = 3;
        tick();
        t = cyc; at = -1; if_seen = 0; got = 0;
        if_req = 1; if_addr = ia;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (if_done === 1'b1) if_seen = 1;
            if (k == 7) begin total++; if (mem_a !== la) begin bad++; $display("FAIL clear_ls_grant got=%h want=%h", mem_a, la); end end
            if (ls_done === 1'b1 && at < 0) begin at = cyc - t; got = ls_rdata; ls_req = 0; end
            if (k == 5) begin
                clear_in = 1; if_req = 0;
                ls_req = 1; ls_wr = 0; ls_len = 2'(llen); ls_addr = la;
            end
            if (k == 6) clear_in = 0;
        end
        total++; if (if_seen != 0) begin bad++; $display("FAIL clear_if_done got=%0d want=0", if_seen); end
        total++; if (at != 9 + llen) begin bad++; $display("FAIL clear_ls_latency got=%0d want=%0d", at, 9 + llen); end
        total++; if (got !== exp_word(int'(la), llen)) begin bad++; $display("FAIL clear_ls_data got=%h want=%h", got, exp_word(int'(la), llen)); end
        $display("clear during fetch: ls_done@%0d len=%0d", at, llen);

        // A store is not affected by clear_in.
        sa = 32'h600 + 4 * 32'($urandom_range(0, 63));
        wd = $urandom;
        tick();
        t = cyc; at = -1; nwr = 0;
        ls_req = 1; ls_wr = 1; ls_len = 3; ls_addr = sa; ls_wdata = wd;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (mem_wr === 1'b1) nwr++;
            if (ls_done === 1'b1 && at < 0) begin at = cyc - t; ls_req = 0; ls_wr = 0; end
            if (k == 1) clear_in = 1;
            if (k == 4) clear_in = 0;
        end
        for (int i = 0; i < 4; i++) ref_mem[(int'(sa) + i) & 4095] = wd[8*i +: 8];
        total++; if (nwr != 4) begin bad++; $display("FAIL clear_store_writes got=%0d want=4", nwr); end
        total++; if (at != 5) begin bad++; $display("FAIL clear_store_latency got=%0d want=5", at); end
        total++; if (ram_word(int'(sa), 3) !== exp_word(int'(sa), 3)) begin bad++; $display("FAIL clear_store_ram got=%h want=%h", ram_word(int'(sa), 3), exp_word(int'(sa), 3)); end
        $display("store under clear: ls_done@%0d writes=%0d", at, nwr);
    endtask

    task automatic test_io_stall();
        int t, at, nwr, wr_at, want_wr, want_done;
        logic [31:0] wr_a;
        logic [7:0] d, wr_d;
`ifdef MEM_ARB_IO_STALL_EN
        want_wr = 4; want_done = 5;
`else
        want_wr = 1; want_done = 2;
`endif
        d = 8'($urandom);
        tick();
        t = cyc; at = -1; nwr = 0; wr_at = -1; wr_a = 0; wr_d = 0;
        ls_req = 1; ls_wr = 1; ls_len = 0; ls_addr = 32'h30000; ls_wdata = {24'h0, d};
        io_buffer_full = 1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (mem_wr === 1'b1) begin nwr++; wr_at = cyc - t; wr_a = mem_a; wr_d = mem_dout; end
            if (ls_done === 1'b1 && at < 0) begin at = cyc - t; ls_req = 0; ls_wr = 0; end
            if (k == 3) io_buffer_full = 0;
        end
        ref_mem[0] = d;
        total++; if (nwr != 1) begin bad++; $display("FAIL io_writes got=%0d want=1", nwr); end
        total++; if (wr_at != want_wr) begin bad++; $display("FAIL io_write_cycle got=%0d want=%0d", wr_at, want_wr); end
        total++; if (wr_a !== 32'h30000 || wr_d !== d) begin bad++; $display("FAIL io_write_data got=%h/%h want=00030000/%h", wr_a, wr_d, d); end
        total++; if (at != want_done) begin bad++; $display("FAIL io_done_cycle got=%0d want=%0d", at, want_done); end
        $display("io store: write@%0d ls_done@%0d", wr_at, at);
    endtask

    task automatic test_random();
        int kind, lsel, len, a, nwr, done, wrong;
        logic [31:0] wd, expv, got;
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 2);
            lsel = $urandom_range(0, 2);
            len  = (kind == 0) ? 3 : (lsel == 0) ? 0 : (lsel == 1) ? 1 : 3;
            a    = $urandom_range(0, 4000);
            wd   = $urandom;
            expv = exp_word(a, len);
            tick();
            if (kind == 0) begin
                if_req = 1; if_addr = 32'(a);
            end else begin
                ls_req = 1; ls_wr = (kind == 2); ls_len = 2'(len); ls_addr = 32'(a); ls_wdata = wd;
            end
            nwr = 0; done = 0; wrong = 0; got = 0;
            for (int k = 0; k < 80 && done == 0; k++) begin
                tick();
                if (mem_wr === 1'b1) nwr++;
                if ((kind == 0 && ls_done === 1'b1) || (kind != 0 && if_done === 1'b1)) wrong++;
                if (kind == 0 && if_done === 1'b1) begin done = 1; got = if_data; if_req = 0; end
                if (kind != 0 && ls_done === 1'b1) begin done = 1; got = ls_rdata; ls_req = 0; ls_wr = 0; end
                rdy_in = ($urandom_range(0, 3) != 0);
            end
            rdy_in = 1;
            total++; if (done == 0) begin bad++; $display("FAIL rand_timeout it=%0d got=no_done want=done", it); end
            total++; if (wrong != 0) begin bad++; $display("FAIL rand_wrong_done it=%0d got=%0d want=0", it, wrong); end
            if (kind == 2) begin
                for (int i = 0; i <= len; i++) ref_mem[(a + i) & 4095] = wd[8*i +: 8];
                total++; if (nwr != len + 1) begin bad++; $display("FAIL rand_store_writes it=%0d got=%0d want=%0d", it, nwr, len + 1); end
                total++; if (ram_word(a, len) !== exp_word(a, len)) begin bad++; $display("FAIL rand_store_ram it=%0d got=%h want=%h", it, ram_word(a, len), exp_word(a, len)); end
                $display("rand it=%0d store a=%h len=%0d data=%h", it, a, len, wd);
            end else begin
                total++; if (nwr != 0) begin bad++; $display("FAIL rand_read_writes it=%0d got=%0d want=0", it, nwr); end
                total++; if (got !== expv) begin bad++; $display("FAIL rand_read_data it=%0d got=%h want=%h", it, got, expv); end
                $display("rand it=%0d %s a=%h len=%0d data=%h", it, (kind == 0) ? "fetch" : "load", a, len, got);
            end
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_if_fetch();
        test_priority();
        test_store();
        test_rdy_stall();
        test_clear();
        test_io_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
